// File: rtl/alu_pkg.sv
// Shared types for the ALU control path: operation and branch-type codes,
// RV32I major opcodes and the decoded control bundle.
package alu_pkg;

    localparam int ALU_OP_W  = 4;
    localparam int BR_TYPE_W = 3;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_AND  = 4'd0,
        ALU_OR   = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SLL  = 4'd3,
        ALU_SRA  = 4'd4,
        ALU_SRL  = 4'd5,
        ALU_SUB  = 4'd6,
        ALU_XOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    typedef enum logic [BR_TYPE_W-1:0] {
        BR_NONE = 3'b000,
        BR_BNE  = 3'b001,
        BR_BEQ  = 3'b010,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } br_type_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef struct packed {
        alu_op_e  Operation;
        br_type_e Branch_Type;
        logic     AluSrc;
        logic     illegal;
    } alu_ctrl_t;

endpackage

// File: rtl/alu_op_issue_if.sv
// Decode-side offer and EX-side delivery of ALU control, valid/ready on both.
interface alu_op_issue_if
    import alu_pkg::*;
#(
    parameter int OPCODE_LENGTH = ALU_OP_W,
    parameter int BRTYPE_WIDTH  = BR_TYPE_W
);
    logic                     id_valid;
    logic                     id_ready;
    logic [6:0]               id_opcode;
    logic [2:0]               id_funct3;
    logic                     id_funct7b5;
    logic                     ex_valid;
    logic                     ex_ready;
    logic [OPCODE_LENGTH-1:0] ex_Operation;
    logic [BRTYPE_WIDTH-1:0]  ex_Branch_Type;
    logic                     ex_AluSrc;
    logic                     ex_illegal;

    modport master (
        output id_valid, id_opcode, id_funct3, id_funct7b5, ex_ready,
        input  id_ready, ex_valid, ex_Operation, ex_Branch_Type,
        input  ex_AluSrc, ex_illegal
    );

    modport slave (
        input  id_valid, id_opcode, id_funct3, id_funct7b5, ex_ready,
        output id_ready, ex_valid, ex_Operation, ex_Branch_Type,
        output ex_AluSrc, ex_illegal
    );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational RV32I field decode into ALU operation, branch type,
// operand-B select and illegal flag.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output alu_ctrl_t  ctrl
);

    alu_op_e alu_fn;

    // Shared R/I funct3 table; the R-type SUB override is applied below.
    always_comb begin
        alu_fn = ALU_ADD;
        unique case (funct3)
            3'b000: alu_fn = ALU_ADD;
            3'b001: alu_fn = ALU_SLL;
            3'b010: alu_fn = ALU_SLT;
            3'b011: alu_fn = ALU_SLTU;
            3'b100: alu_fn = ALU_XOR;
            3'b101: alu_fn = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110: alu_fn = ALU_OR;
            3'b111: alu_fn = ALU_AND;
        endcase
    end

    always_comb begin
        ctrl.Operation   = ALU_ADD;
        ctrl.Branch_Type = BR_NONE;
        ctrl.AluSrc      = 1'b0;
        ctrl.illegal     = 1'b0;
        unique case (opcode)
            OP_R: begin
                if (funct3 == 3'b000 && funct7b5)
                    ctrl.Operation = ALU_SUB;
                else
                    ctrl.Operation = alu_fn;
            end
            OP_IMM: begin
                ctrl.Operation = alu_fn;
                ctrl.AluSrc    = 1'b1;
            end
            OP_LOAD, OP_STORE, OP_LUI,
            OP_AUIPC, OP_JAL, OP_JALR: begin
                ctrl.AluSrc = 1'b1;
            end
            OP_BRANCH: begin
                ctrl.Operation = ALU_SUB;
                unique case (funct3)
                    3'b000: ctrl.Branch_Type = BR_BEQ;
                    3'b001: ctrl.Branch_Type = BR_BNE;
                    3'b100: ctrl.Branch_Type = BR_BLT;
                    3'b101: ctrl.Branch_Type = BR_BGE;
                    3'b110: ctrl.Branch_Type = BR_BLTU;
                    3'b111: ctrl.Branch_Type = BR_BGEU;
                    3'b010, 3'b011: ctrl.illegal = 1'b1;
                endcase
            end
            default: begin
                ctrl.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_op_issue.sv
// ID/EX boundary for ALU control: decode, then a main register plus a
// one-entry skid so id_ready never depends combinationally on ex_ready.
module alu_op_issue
    import alu_pkg::*;
#(
    parameter int OPCODE_LENGTH = ALU_OP_W,
    parameter int BRTYPE_WIDTH  = BR_TYPE_W
)(
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    alu_op_issue_if.slave bus
);

    alu_ctrl_t dec;
    alu_ctrl_t main_q, main_d;
    alu_ctrl_t skid_q, skid_d;
    logic      main_v_q, main_v_d;
    logic      skid_v_q, skid_v_d;
    logic      id_rdy;
    logic      accept;
    logic      pop;

    alu_op_decode u_decode (
        .opcode   (bus.id_opcode),
        .funct3   (bus.id_funct3),
        .funct7b5 (bus.id_funct7b5),
        .ctrl     (dec)
    );

    assign id_rdy = !skid_v_q && !reset;
    assign accept = bus.id_valid && id_rdy;
    assign pop    = main_v_q && bus.ex_ready;

    always_comb begin
        main_d   = main_q;
        main_v_d = main_v_q;
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (!main_v_q || pop) begin
            if (skid_v_q) begin
                main_d   = skid_q;
                main_v_d = 1'b1;
                skid_v_d = accept;
                if (accept)
                    skid_d = dec;
            end else begin
                main_v_d = accept;
                if (accept)
                    main_d = dec;
            end
        end else if (accept) begin
            skid_d   = dec;
            skid_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
        end else begin
            main_q   <= main_d;
            skid_q   <= skid_d;
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
        end
    end

    assign bus.id_ready       = id_rdy;
    assign bus.ex_valid       = main_v_q;
    assign bus.ex_Operation   = OPCODE_LENGTH'(main_q.Operation);
    assign bus.ex_Branch_Type = BRTYPE_WIDTH'(main_q.Branch_Type);
    assign bus.ex_AluSrc      = main_q.AluSrc;
    assign bus.ex_illegal     = main_q.illegal;

endmodule
